// File: rtl/rob_retire_unit_pkg.sv
// Shared types and constants for the reorder buffer: entry layout and the
// completion broadcasts coming back from the ALU, memory and branch units.
package rob_retire_unit_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 5;
  localparam int PC_W      = 32;
  localparam int PREG_W    = 7;

  typedef struct packed {
    logic                 valid;
    logic                 complete;
    logic [PC_W-1:0]      pc;
    logic [PREG_W-1:0]    pd_new;
    logic [PREG_W-1:0]    pd_old;
    logic [ROB_TAG_W-1:0] rob_index;
  } rob_data;

  typedef struct packed {
    logic                 fu_alu_done;
    logic [ROB_TAG_W-1:0] rob_fu_alu;
  } alu_data;

  typedef struct packed {
    logic                 fu_mem_done;
    logic [ROB_TAG_W-1:0] rob_fu_mem;
  } mem_data;

  typedef struct packed {
    logic                 fu_b_done;
    logic [ROB_TAG_W-1:0] rob_fu_b;
    logic                 mispredict;
    logic [ROB_TAG_W-1:0] mispredict_tag;
  } b_data;

  // A tag names a real entry only when it is below the configured depth.
  function automatic logic tag_in_range(input logic [ROB_TAG_W-1:0] tag, input int depth);
    return ({27'd0, tag} < depth);
  endfunction

endpackage

// File: rtl/rob_retire_unit_if.sv
// Allocation, completion and commit bundle of the reorder buffer.
// slave is the ROB's view; master is the rename/FU/commit environment.
interface rob_retire_unit_if;
  import rob_retire_unit_pkg::*;

  logic                 alloc_valid;
  logic [PC_W-1:0]      alloc_pc;
  logic [PREG_W-1:0]    alloc_pd_new;
  logic [PREG_W-1:0]    alloc_pd_old;
  logic                 alloc_ready;
  logic [ROB_TAG_W-1:0] alloc_tag;
  alu_data              alu_in;
  mem_data              mem_in;
  b_data                b_in;
  logic                 commit_valid;
  logic [PREG_W-1:0]    commit_pd_old;
  logic [PREG_W-1:0]    commit_pd_new;
  logic [PC_W-1:0]      commit_pc;
  logic [ROB_TAG_W-1:0] commit_tag;
  logic                 flush;
  logic                 rob_empty;

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pd_new, alloc_pd_old, alu_in, mem_in, b_in,
    output alloc_ready, alloc_tag, commit_valid, commit_pd_old, commit_pd_new,
           commit_pc, commit_tag, flush, rob_empty
  );

  modport master (
    output alloc_valid, alloc_pc, alloc_pd_new, alloc_pd_old, alu_in, mem_in, b_in,
    input  alloc_ready, alloc_tag, commit_valid, commit_pd_old, commit_pd_new,
           commit_pc, commit_tag, flush, rob_empty
  );

endinterface

// File: rtl/rob_retire_unit_age_cmp.sv
// Age comparator: true when idx is strictly younger than tag, both ages
// measured from head modulo the ROB depth.
module rob_age_cmp #(
  parameter int PTR_W = 4
) (
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W-1:0] idx,
  input  logic [PTR_W-1:0] tag,
  output logic             younger_than_tag
);

  logic [PTR_W-1:0] idx_age_s;
  logic [PTR_W-1:0] tag_age_s;

  // Modular subtraction gives the distance from the oldest entry.
  always_comb begin
    idx_age_s        = idx - head;
    tag_age_s        = tag - head;
    younger_than_tag = (idx_age_s > tag_age_s);
  end

endmodule

// File: rtl/rob_retire_unit.sv
// In-order reorder buffer: allocates at tail, marks completions from three
// FUs, retires one complete head entry per cycle and squashes on mispredict.
module rob_retire_unit
  import rob_retire_unit_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  rob_retire_unit_if.slave rob
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  rob_data          entries_q [DEPTH];
  rob_data          entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             flush_q, flush_d;

  logic [DEPTH-1:0] younger_s;
  logic [PTR_W-1:0] alu_tag_s, mem_tag_s, b_tag_s, mp_tag_s, mp_age_s;
  logic             alu_hit_s, mem_hit_s, b_hit_s;
  logic             mispredict_s, alloc_fire_s, commit_fire_s;

  assign alu_tag_s = rob.alu_in.rob_fu_alu[PTR_W-1:0];
  assign mem_tag_s = rob.mem_in.rob_fu_mem[PTR_W-1:0];
  assign b_tag_s   = rob.b_in.rob_fu_b[PTR_W-1:0];
  assign mp_tag_s  = rob.b_in.mispredict_tag[PTR_W-1:0];
  assign mp_age_s  = mp_tag_s - head_q;

  // Completions only land on live entries; stale tags are dropped.
  assign alu_hit_s = rob.alu_in.fu_alu_done & tag_in_range(rob.alu_in.rob_fu_alu, DEPTH)
                     & entries_q[alu_tag_s].valid;
  assign mem_hit_s = rob.mem_in.fu_mem_done & tag_in_range(rob.mem_in.rob_fu_mem, DEPTH)
                     & entries_q[mem_tag_s].valid;
  assign b_hit_s   = rob.b_in.fu_b_done & tag_in_range(rob.b_in.rob_fu_b, DEPTH)
                     & entries_q[b_tag_s].valid;

  assign mispredict_s  = rob.b_in.fu_b_done & rob.b_in.mispredict
                         & tag_in_range(rob.b_in.mispredict_tag, DEPTH);
  assign alloc_fire_s  = rob.alloc_valid & rob.alloc_ready & ~mispredict_s;
  assign commit_fire_s = rob.commit_valid;

  assign rob.alloc_ready   = (count_q < DEPTH_C);
  assign rob.alloc_tag     = ROB_TAG_W'(tail_q);
  assign rob.rob_empty     = (count_q == {(PTR_W+1){1'b0}});
  assign rob.commit_valid  = entries_q[head_q].valid & entries_q[head_q].complete;
  assign rob.commit_pd_old = entries_q[head_q].pd_old;
  assign rob.commit_pd_new = entries_q[head_q].pd_new;
  assign rob.commit_pc     = entries_q[head_q].pc;
  assign rob.commit_tag    = entries_q[head_q].rob_index;
  assign rob.flush         = flush_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    rob_age_cmp #(.PTR_W(PTR_W)) u_age (
      .head             (head_q),
      .idx              (PTR_W'(i)),
      .tag              (mp_tag_s),
      .younger_than_tag (younger_s[i])
    );
  end

  // Entry updates in priority order: alloc, completions, squash, retire.
  always_comb begin
    entries_d = entries_q;
    if (alloc_fire_s) begin
      entries_d[tail_q] = '{valid: 1'b1, complete: 1'b0, pc: rob.alloc_pc,
                            pd_new: rob.alloc_pd_new, pd_old: rob.alloc_pd_old,
                            rob_index: ROB_TAG_W'(tail_q)};
    end else begin
      entries_d[tail_q] = entries_q[tail_q];
    end
    entries_d[alu_tag_s].complete = entries_d[alu_tag_s].complete | alu_hit_s;
    entries_d[mem_tag_s].complete = entries_d[mem_tag_s].complete | mem_hit_s;
    entries_d[b_tag_s].complete   = entries_d[b_tag_s].complete | b_hit_s;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i].valid    = entries_d[i].valid & ~(mispredict_s & younger_s[i]);
      entries_d[i].complete = entries_d[i].complete & ~(mispredict_s & younger_s[i]);
    end
    entries_d[mp_tag_s].complete = entries_d[mp_tag_s].complete
                                   | (mispredict_s & entries_q[mp_tag_s].valid);
    entries_d[head_q].valid    = entries_d[head_q].valid & ~commit_fire_s;
    entries_d[head_q].complete = entries_d[head_q].complete & ~commit_fire_s;
  end

  // Pointer and occupancy bookkeeping; a mispredict rebuilds tail and count.
  always_comb begin
    head_d  = head_q + PTR_W'(commit_fire_s);
    flush_d = mispredict_s;
    if (mispredict_s) begin
      tail_d  = mp_tag_s + PTR_W'(1'b1);
      count_d = {1'b0, mp_age_s} + (PTR_W+1)'(1'b1) - (PTR_W+1)'(commit_fire_s);
    end else begin
      tail_d  = tail_q + PTR_W'(alloc_fire_s);
      count_d = count_q + (PTR_W+1)'(alloc_fire_s) - (PTR_W+1)'(commit_fire_s);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {(PTR_W+1){1'b0}};
      flush_q <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_rob_retire_unit.sv
// Scoreboard bench for rob_retire_unit: allocations push the expected commit
// record; a negedge monitor pops and compares every retiring instruction.
module tb_rob_retire_unit;
  import rob_retire_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;

  rob_retire_unit_if ifc ();

  rob_retire_unit #(.DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (ifc.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          flush_seen = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_act, mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_c(input logic [4:0] tag, input logic [31:0] pc,
                                         input logic [6:0] pn, input logic [6:0] po);
    return {13'd0, tag, pc, pn, po};
  endfunction

  // Monitor: every retiring instruction must be the oldest expected one.
  always @(negedge clk) begin
    if (!reset && ifc.commit_valid) begin
      mon_act = pack_c(ifc.commit_tag, ifc.commit_pc, ifc.commit_pd_new, ifc.commit_pd_old);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL commit_unexpected: got %0h want no commit", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("commit", mon_act, mon_exp);
      end
    end
    if (!reset && ifc.flush) flush_seen++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ifc.alloc_valid  = 1'b0;
    ifc.alloc_pc     = 32'd0;
    ifc.alloc_pd_new = 7'd0;
    ifc.alloc_pd_old = 7'd0;
    ifc.alu_in       = '0;
    ifc.mem_in       = '0;
    ifc.b_in         = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    exp_q.delete();
    flush_seen = 0;
    reset = 1'b0;
    tick();
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [6:0] pn, input logic [6:0] po,
                       input logic [4:0] exp_tag);
    chk("alloc_ready", {63'd0, ifc.alloc_ready}, 64'd1);
    chk("alloc_tag", {59'd0, ifc.alloc_tag}, {59'd0, exp_tag});
    ifc.alloc_valid  = 1'b1;
    ifc.alloc_pc     = pc;
    ifc.alloc_pd_new = pn;
    ifc.alloc_pd_old = po;
    exp_q.push_back(pack_c(exp_tag, pc, pn, po));
    tick();
    ifc.alloc_valid = 1'b0;
  endtask

  task automatic complete(input int fu, input logic [4:0] tag);
    case (fu)
      0:       begin ifc.alu_in.fu_alu_done = 1'b1; ifc.alu_in.rob_fu_alu = tag; end
      1:       begin ifc.mem_in.fu_mem_done = 1'b1; ifc.mem_in.rob_fu_mem = tag; end
      default: begin ifc.b_in.fu_b_done = 1'b1; ifc.b_in.rob_fu_b = tag; end
    endcase
    tick();
    ifc.alu_in = '0;
    ifc.mem_in = '0;
    ifc.b_in   = '0;
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    while (!(ifc.rob_empty && exp_q.size() == 0) && k < 64) begin
      tick();
      k++;
    end
    chk({name, "_empty"}, {63'd0, ifc.rob_empty}, 64'd1);
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset values, both while asserted and after release.
    reset = 1'b1;
    idle_inputs();
    tick();
    chk("rst_alloc_ready", {63'd0, ifc.alloc_ready}, 64'd1);
    chk("rst_rob_empty", {63'd0, ifc.rob_empty}, 64'd1);
    chk("rst_commit_valid", {63'd0, ifc.commit_valid}, 64'd0);
    chk("rst_flush", {63'd0, ifc.flush}, 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_alloc_ready", {63'd0, ifc.alloc_ready}, 64'd1);
    chk("idle_commit_valid", {63'd0, ifc.commit_valid}, 64'd0);
    chk("idle_alloc_tag", {59'd0, ifc.alloc_tag}, 64'd0);

    // Fill all 16 entries; a 17th request is ignored.
    for (int i = 0; i < 16; i++) alloc(32'(i * 4), 7'(32 + i), 7'(i), 5'(i));
    chk("full_alloc_ready", {63'd0, ifc.alloc_ready}, 64'd0);
    chk("full_rob_empty", {63'd0, ifc.rob_empty}, 64'd0);
    ifc.alloc_valid = 1'b1;
    ifc.alloc_pc    = 32'h0000_BAD0;
    tick();
    ifc.alloc_valid = 1'b0;
    chk("full_tail_stays", {59'd0, ifc.alloc_tag}, 64'd0);
    chk("full_still_full", {63'd0, ifc.alloc_ready}, 64'd0);
    for (int i = 0; i < 16; i++) complete(i % 3, 5'(i));
    wait_empty("fill");

    // Out-of-order completion, duplicate tag, in-order retirement.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32'h40 + 32'(i * 4), 7'(40 + i), 7'(8 + i), 5'(i));
    ifc.alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd2};
    ifc.mem_in = '{fu_mem_done: 1'b1, rob_fu_mem: 5'd2};
    tick();
    ifc.alu_in = '0;
    ifc.mem_in = '0;
    chk("ooo_no_commit_a", {63'd0, ifc.commit_valid}, 64'd0);
    complete(0, 5'd1);
    chk("ooo_no_commit_b", {63'd0, ifc.commit_valid}, 64'd0);
    ifc.alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd0};
    chk("head_not_early", {63'd0, ifc.commit_valid}, 64'd0);
    tick();
    ifc.alu_in = '0;
    chk("head_visible_next", {63'd0, ifc.commit_valid}, 64'd1);
    wait_empty("ooo");

    // Mispredict on tag 2 squashes 3..5 and drops a same-cycle alloc.
    do_reset();
    for (int i = 0; i < 6; i++) alloc(32'h100 + 32'(i * 4), 7'(64 + i), 7'(16 + i), 5'(i));
    ifc.b_in = '{fu_b_done: 1'b1, rob_fu_b: 5'd2, mispredict: 1'b1, mispredict_tag: 5'd2};
    ifc.alloc_valid = 1'b1;
    ifc.alloc_pc    = 32'hDEAD_0000;
    tick();
    ifc.b_in = '0;
    ifc.alloc_valid = 1'b0;
    for (int i = 0; i < 3; i++) void'(exp_q.pop_back());
    chk("mp_tail", {59'd0, ifc.alloc_tag}, 64'd3);
    chk("mp_flush_on", {63'd0, ifc.flush}, 64'd1);
    tick();
    chk("mp_flush_off", {63'd0, ifc.flush}, 64'd0);
    complete(0, 5'd4);
    alloc(32'h200, 7'd90, 7'd91, 5'd3);
    alloc(32'h204, 7'd92, 7'd93, 5'd4);
    complete(0, 5'd0);
    complete(1, 5'd1);
    complete(0, 5'd3);
    tick();
    tick();
    tick();
    chk("mp_tag4_pending", {63'd0, ifc.commit_valid}, 64'd0);
    chk("mp_not_empty", {63'd0, ifc.rob_empty}, 64'd0);
    complete(2, 5'd4);
    wait_empty("mp");
    chk("mp_flush_count", 64'(flush_seen), 64'd1);

    // Rate-1 streaming across the pointer wrap.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      chk("wrap_alloc_tag", {59'd0, ifc.alloc_tag}, 64'(k % 16));
      ifc.alloc_valid  = 1'b1;
      ifc.alloc_pc     = 32'h1000 + 32'(k * 4);
      ifc.alloc_pd_new = 7'(k);
      ifc.alloc_pd_old = 7'(k + 1);
      exp_q.push_back(pack_c(5'(k % 16), 32'h1000 + 32'(k * 4), 7'(k), 7'(k + 1)));
      if (k > 0) ifc.alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'((k - 1) % 16)};
      tick();
      ifc.alloc_valid = 1'b0;
      ifc.alu_in      = '0;
    end
    complete(0, 5'd7);
    wait_empty("wrap");

    // Full with a retiring head: alloc rejected, accepted next cycle.
    do_reset();
    for (int i = 0; i < 16; i++) alloc(32'h2000 + 32'(i * 4), 7'(i), 7'(100 + i), 5'(i));
    complete(0, 5'd0);
    ifc.alloc_valid  = 1'b1;
    ifc.alloc_pc     = 32'h3000;
    ifc.alloc_pd_new = 7'd55;
    ifc.alloc_pd_old = 7'd66;
    chk("fc_ready_low", {63'd0, ifc.alloc_ready}, 64'd0);
    chk("fc_commit", {63'd0, ifc.commit_valid}, 64'd1);
    tick();
    chk("fc_ready_after", {63'd0, ifc.alloc_ready}, 64'd1);
    chk("fc_tag_freed", {59'd0, ifc.alloc_tag}, 64'd0);
    exp_q.push_back(pack_c(5'd0, 32'h3000, 7'd55, 7'd66));
    tick();
    ifc.alloc_valid = 1'b0;
    chk("fc_full_again", {63'd0, ifc.alloc_ready}, 64'd0);
    for (int i = 1; i < 16; i++) complete(i % 3, 5'(i));
    complete(0, 5'd0);
    wait_empty("fc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_retire_unit.md
Name: rob_retire_unit

Overview:
Reorder buffer that accepts renamed instructions in program order and receives completion broadcasts from the ALU, branch and memory FUs (alu_data, b_data, mem_data). It retires one instruction per cycle in order, and releases pd_old to the free list. It also squashes younger entries on a branch mispredict. Sits between rename/dispatch (allocation side) and the free list / architectural map (commit side).

Parameters:
DEPTH, 16, number of ROB entries; power of two, 2..32 (tag is 5 bits).
PTR_W, $clog2(DEPTH), head/tail pointer width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
alloc_valid  in  1  rename presents an instruction
alloc_pc  in  32  instruction pc
alloc_pd_new  in  7  newly mapped physical dest
alloc_pd_old  in  7  previous mapping of rd
alloc_ready  out  1  ROB not full (registered count < DEPTH)
alloc_tag  out  5  tag assigned to the current alloc (= tail, zero-extended)
alu_in  in  alu_data  ALU completion broadcast
mem_in  in  mem_data  memory completion broadcast
b_in  in  b_data  branch completion and mispredict info
commit_valid  out  1  one instruction retires this cycle
commit_pd_old  out  7  register returned to free list
commit_pd_new  out  7  register made architectural
commit_pc  out  32  retiring pc
commit_tag  out  5  retiring ROB index
flush  out  1  registered one-cycle pulse, cycle after mispredict accepted
rob_empty  out  1  count == 0

Behaviour:
- Storage: DEPTH x rob_data entries. Registers: head, tail (PTR_W), count (PTR_W+1).
- Reset (async, asserted): all entry valid/complete = 0; head = tail = count = 0.
- Reset values of outputs: alloc_ready = 1, rob_empty = 1, commit_valid = 0, flush = 0.
- Allocate: fires when alloc_valid & alloc_ready & no mispredict this cycle.
  - Entry[tail] is written with valid = 1, complete = 0, pc, pd_new, pd_old, rob_index = tail.
  - tail increments mod DEPTH; alloc_tag is valid in the same cycle, combinationally equal to tail.
- alloc_ready derives from registered count only; a commit in the same cycle does not bypass into it.
- Completion: for each FU with done = 1, set entry[rob_fu_*].complete = 1 on the clock edge, only if that entry is valid. Completions to invalid entries are ignored.
  - Up to 3 completions per cycle, to distinct tags.
  - The same tag arriving twice is idempotent.
- Commit: combinational commit_valid = entry[head].valid & entry[head].complete. commit_* fields come from entry[head].
  - On the edge: entry[head].valid = 0, head++ mod DEPTH.
  - At most 1 commit per cycle; completion of the head entry is visible at the earliest the cycle after it arrives.
- Mispredict: b_in.fu_b_done & b_in.mispredict.
  - Every valid entry whose age (idx - head mod DEPTH) exceeds the age of mispredict_tag is cleared (valid = 0, complete = 0).
  - The branch entry itself is kept and marked complete.
  - tail = mispredict_tag + 1 mod DEPTH; count = age(tag) + 1, minus 1 if a commit fires in the same cycle.
  - Any alloc in that cycle is dropped.
  - flush pulses the next cycle.
- Free-list restoration of squashed pd_new values is not done here; rename recovers via checkpoint.
- count update: +alloc -commit, both allowed in the same cycle (count unchanged). Mispredict overrides as above.
- Full (count == DEPTH): alloc_ready = 0; alloc_valid is ignored.
- Empty: commit_valid = 0.
- Wrap-around: pointers wrap mod DEPTH. Full and empty are distinguished by count, never by pointer equality.
- Reset mid-operation: the whole state clears immediately; no commit is emitted.

Decomposition:
- Shared package: existing rob_data, alu_data, mem_data, b_data; add constant ROB_DEPTH = 16 and localparam ROB_TAG_W = 5.
- One natural sub-module: rob_age_cmp (combinational; head, idx, tag -> younger_than_tag), instantiated per entry for the squash mask.

Test Plan:
- Reset, then idle -> alloc_ready = 1, rob_empty = 1, commit_valid = 0, flush = 0.
- Allocate 16 instructions (pc 0x0..0x3C) with no completions -> alloc_ready = 0 after the 16th. A 17th alloc_valid is ignored and tail stays 0.
- Allocate tags 0,1,2; complete 2 then 1 then 0 via ALU -> commits occur in order 0,1,2 on consecutive cycles. commit_pd_old matches the values allocated.
- Allocate tags 0..5; branch on tag 2 reports mispredict -> entries 3..5 are cleared, tail = 3, flush pulses once next cycle. Later completions to tag 4 are ignored.
- Wrap: run 40 alloc/complete/commit cycles at rate 1 -> alloc_tag sequence wraps 15 -> 0 and commits stay in order.
- With count = 16 and head complete, assert alloc_valid -> the commit fires and the alloc is rejected. The next cycle the alloc is accepted into the freed slot.
